// File: rtl/control_v3_ip.sv
// AXI4-Lite control/status register block: NUM_RW read/write registers followed by NUM_RO status words.
// Optional build macro CONTROL_V3_IP_SELF_CLEAR_EN turns RW register 0 into a self-clearing command register.
module control_v3_ip #(
    parameter int C_DATA_W = 32,
    parameter int C_ADDR_W = 6,
    parameter int NUM_RW   = 4,
    parameter int NUM_RO   = 2
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic [C_ADDR_W-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                   S_AXI_AWPROT,
    input  logic                         S_AXI_AWVALID,
    output logic                         S_AXI_AWREADY,
    input  logic [C_DATA_W-1:0]          S_AXI_WDATA,
    input  logic [C_DATA_W/8-1:0]        S_AXI_WSTRB,
    input  logic                         S_AXI_WVALID,
    output logic                         S_AXI_WREADY,
    output logic [1:0]                   S_AXI_BRESP,
    output logic                         S_AXI_BVALID,
    input  logic                         S_AXI_BREADY,
    input  logic [C_ADDR_W-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                   S_AXI_ARPROT,
    input  logic                         S_AXI_ARVALID,
    output logic                         S_AXI_ARREADY,
    output logic [C_DATA_W-1:0]          S_AXI_RDATA,
    output logic [1:0]                   S_AXI_RRESP,
    output logic                         S_AXI_RVALID,
    input  logic                         S_AXI_RREADY,
    output logic [NUM_RW*C_DATA_W-1:0]   ctrl_q,
    output logic [NUM_RW-1:0]            wr_pulse,
    input  logic [NUM_RO*C_DATA_W-1:0]   status_i
);

    localparam int STRB_W   = C_DATA_W / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = C_ADDR_W - ADDR_LSB;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef CONTROL_V3_IP_SELF_CLEAR_EN
    localparam int SC_LO = 1;
`else
    localparam int SC_LO = 0;
`endif

    typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    w_state_t               w_state_r, w_state_nxt_s;
    r_state_t               r_state_r, r_state_nxt_s;
    logic                   live_r;
    logic                   aw_held_r, w_held_r;
    logic [IDX_W-1:0]       aw_idx_r;
    logic [C_DATA_W-1:0]    w_data_r;
    logic [STRB_W-1:0]      w_strb_r;
    logic                   aw_hs_s, w_hs_s, commit_s, b_hs_s, ar_hs_s, r_hs_s;
    logic [31:0]            aw_sel_s, ar_sel_s;
    logic                   wr_hit_s;
    logic [1:0]             bresp_r;
    logic [C_DATA_W-1:0]    ctrl_r     [NUM_RW];
    logic [C_DATA_W-1:0]    ctrl_nxt_s [NUM_RW];
    logic [NUM_RW-1:0]      wr_pulse_r, wr_pulse_nxt_s;
    logic [C_DATA_W-1:0]    rdata_r, rd_data_s;
    logic [1:0]             rresp_r, rd_resp_s;
    logic                   unused_s;

    assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    assign aw_hs_s  = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs_s   = S_AXI_WVALID & S_AXI_WREADY;
    assign b_hs_s   = S_AXI_BVALID & S_AXI_BREADY;
    assign ar_hs_s  = S_AXI_ARVALID & S_AXI_ARREADY;
    assign r_hs_s   = S_AXI_RVALID & S_AXI_RREADY;
    assign commit_s = (w_state_r == W_IDLE) & aw_held_r & w_held_r;
    assign aw_sel_s = 32'(aw_idx_r);
    assign ar_sel_s = 32'(S_AXI_ARADDR[C_ADDR_W-1:ADDR_LSB]);
    assign wr_hit_s = (aw_sel_s < 32'(NUM_RW));

    assign S_AXI_BRESP = bresp_r;
    assign S_AXI_RDATA = rdata_r;
    assign S_AXI_RRESP = rresp_r;
    assign wr_pulse    = wr_pulse_r;

    // State registers for both FSMs; live_r keeps readies low until the cycle after reset releases
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_r <= W_IDLE;
            r_state_r <= R_IDLE;
            live_r    <= 1'b0;
        end else begin
            w_state_r <= w_state_nxt_s;
            r_state_r <= r_state_nxt_s;
            live_r    <= 1'b1;
        end
    end

    // Write FSM next state
    always_comb begin
        case (w_state_r)
            W_IDLE:  w_state_nxt_s = commit_s ? W_RESP : W_IDLE;
            W_RESP:  w_state_nxt_s = b_hs_s ? W_IDLE : W_RESP;
            default: w_state_nxt_s = W_IDLE;
        endcase
    end

    // Write FSM outputs, decoded from registers only
    always_comb begin
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        case (w_state_r)
            W_IDLE: begin
                S_AXI_AWREADY = live_r & ~aw_held_r;
                S_AXI_WREADY  = live_r & ~w_held_r;
            end
            W_RESP:  S_AXI_BVALID = 1'b1;
            default: S_AXI_BVALID = 1'b0;
        endcase
    end

    // Read FSM next state
    always_comb begin
        case (r_state_r)
            R_IDLE:  r_state_nxt_s = ar_hs_s ? R_DATA : R_IDLE;
            R_DATA:  r_state_nxt_s = r_hs_s ? R_IDLE : R_DATA;
            default: r_state_nxt_s = R_IDLE;
        endcase
    end

    // Read FSM outputs
    always_comb begin
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        case (r_state_r)
            R_IDLE:  S_AXI_ARREADY = live_r;
            R_DATA:  S_AXI_RVALID  = 1'b1;
            default: S_AXI_RVALID  = 1'b0;
        endcase
    end

    // Address and data holding registers; AW and W are collected independently
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            aw_idx_r  <= '0;
            w_data_r  <= '0;
            w_strb_r  <= '0;
        end else begin
            if (aw_hs_s) begin
                aw_held_r <= 1'b1;
                aw_idx_r  <= S_AXI_AWADDR[C_ADDR_W-1:ADDR_LSB];
            end else if (commit_s) begin
                aw_held_r <= 1'b0;
            end
            if (w_hs_s) begin
                w_held_r <= 1'b1;
                w_data_r <= S_AXI_WDATA;
                w_strb_r <= S_AXI_WSTRB;
            end else if (commit_s) begin
                w_held_r <= 1'b0;
            end
        end
    end

    // Next register contents: byte-lane merge on commit, command register falls back to zero
    always_comb begin
        wr_pulse_nxt_s = '0;
        for (int k = 0; k < NUM_RW; k++) begin
            ctrl_nxt_s[k] = (k < SC_LO) ? '0 : ctrl_r[k];
            if (commit_s && (aw_sel_s == 32'(k))) begin
                wr_pulse_nxt_s[k] = 1'b1;
                for (int b = 0; b < STRB_W; b++) begin
                    ctrl_nxt_s[k][b*8 +: 8] = w_strb_r[b] ? w_data_r[b*8 +: 8] : ctrl_nxt_s[k][b*8 +: 8];
                end
            end else begin
                wr_pulse_nxt_s[k] = 1'b0;
            end
        end
    end

    // RW registers, commit strobes and write response
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int k = 0; k < NUM_RW; k++) begin
                ctrl_r[k] <= '0;
            end
            wr_pulse_r <= '0;
            bresp_r    <= 2'b00;
        end else begin
            for (int k = 0; k < NUM_RW; k++) begin
                ctrl_r[k] <= ctrl_nxt_s[k];
            end
            wr_pulse_r <= wr_pulse_nxt_s;
            if (commit_s) begin
                bresp_r <= wr_hit_s ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Flatten RW registers onto ctrl_q
    always_comb begin
        ctrl_q = '0;
        for (int k = 0; k < NUM_RW; k++) begin
            ctrl_q[k*C_DATA_W +: C_DATA_W] = ctrl_r[k];
        end
    end

    // Read decode: RW registers, then status words, anything else is SLVERR with zero data
    always_comb begin
        rd_data_s = '0;
        rd_resp_s = RESP_SLVERR;
        for (int k = 0; k < NUM_RW; k++) begin
            rd_data_s = rd_data_s | (((ar_sel_s == 32'(k)) && (k >= SC_LO)) ? ctrl_r[k] : '0);
            rd_resp_s = (ar_sel_s == 32'(k)) ? RESP_OKAY : rd_resp_s;
        end
        for (int k = 0; k < NUM_RO; k++) begin
            rd_data_s = rd_data_s | ((ar_sel_s == 32'(NUM_RW + k)) ? status_i[k*C_DATA_W +: C_DATA_W] : '0);
            rd_resp_s = (ar_sel_s == 32'(NUM_RW + k)) ? RESP_OKAY : rd_resp_s;
        end
    end

    // Read data/response captured at the AR handshake and held until accepted
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rdata_r <= '0;
            rresp_r <= 2'b00;
        end else if (ar_hs_s) begin
            rdata_r <= rd_data_s;
            rresp_r <= rd_resp_s;
        end
    end

endmodule

// File: doc/control_v3_ip.md
CONTROL_V3_IP -- requirements
Module: control_v3_ip

Interface
REQ-001 SHALL have parameter C_DATA_W, 32, AXI4-Lite data width in bits (32 or 64).
REQ-002 SHALL have parameter C_ADDR_W, 6, AXI4-Lite address width in bits.
REQ-003 SHALL have parameter NUM_RW, 4, number of read/write control registers (1..32).
REQ-004 SHALL have parameter NUM_RO, 2, number of read-only status registers (0..32).
REQ-005 SHALL have port ACLK, in, 1, the single clock; all logic rising-edge.
REQ-006 SHALL have port ARESET, in, 1; one clock, reset synchronous and active-high.
REQ-007 SHALL have write address ports: S_AXI_AWADDR in C_ADDR_W; S_AXI_AWPROT in 3, ignored; S_AXI_AWVALID in 1; S_AXI_AWREADY out 1.
REQ-008 SHALL have write data ports: S_AXI_WDATA in C_DATA_W; S_AXI_WSTRB in C_DATA_W/8; S_AXI_WVALID in 1; S_AXI_WREADY out 1.
REQ-009 SHALL have write response ports: S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1.
REQ-010 SHALL have read address ports: S_AXI_ARADDR in C_ADDR_W; S_AXI_ARPROT in 3, ignored; S_AXI_ARVALID in 1; S_AXI_ARREADY out 1.
REQ-011 SHALL have read data ports: S_AXI_RDATA out C_DATA_W; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1.
REQ-012 SHALL have ctrl_q, out, NUM_RW*C_DATA_W: flattened RW register contents, register k at bits [k*C_DATA_W +: C_DATA_W].
REQ-013 SHALL have wr_pulse, out, NUM_RW: one-cycle strobe per RW register on write commit.
REQ-014 SHALL have status_i, in, NUM_RO*C_DATA_W: flattened status values, same packing as ctrl_q.

Function
REQ-015 SHALL decode index = ADDR[C_ADDR_W-1:log2(C_DATA_W/8)], ignoring the byte-offset bits.
REQ-016 SHALL map index 0..NUM_RW-1 to RW registers, NUM_RW..NUM_RW+NUM_RO-1 to status, and anything higher to an unmapped location.
REQ-017 SHALL accept AW and W independently in any order or the same cycle; AWREADY is high while no address is held and WREADY is high while no data is held.
REQ-018 Write FSM SHALL have states W_IDLE (collecting), W_RESP (BVALID high); W_IDLE to W_RESP on the edge after both are held; W_RESP to W_IDLE on BVALID&&BREADY.
REQ-019 Write commit SHALL occur on the W_IDLE-to-W_RESP edge; only lanes with WSTRB=1 update; wr_pulse[k] is high exactly the following cycle.
REQ-020 BVALID SHALL rise 1 cycle after the later AW/W handshake; AWREADY=WREADY=0 in W_RESP.
REQ-021 Write to a status or unmapped index SHALL change no register, pulse nothing, and return BRESP=SLVERR (2'b10); a mapped RW index returns OKAY.
REQ-022 Read FSM SHALL have states R_IDLE (ARREADY=1), R_DATA (RVALID=1); R_IDLE to R_DATA on AR handshake, with RDATA/RRESP registered on that edge; R_DATA to R_IDLE on RVALID&&RREADY.
REQ-023 Read of an unmapped index SHALL return RDATA=0 and RRESP=SLVERR; status reads sample status_i at the AR handshake edge.
REQ-024 Read and write paths SHALL be independent; an AR handshake on the same edge as a write commit to the same register returns the pre-write value.
REQ-025 RDATA/RRESP and BRESP SHALL be held stable while their VALID is high and not accepted.

Reset
REQ-026 SHALL, on ARESET high at a rising edge, clear all RW registers to 0, drop held AW/W, and enter W_IDLE and R_IDLE.
REQ-027 Outputs SHALL read during reset: AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, wr_pulse=0, ctrl_q=0.
REQ-028 Reset mid-transaction SHALL abandon it with no response; ready signals reassert the first cycle after ARESET deasserts.

Configuration
REQ-029 Macro CONTROL_V3_IP_SELF_CLEAR_EN: when defined, RW register 0 is a command register whose committed bits stay set for exactly one cycle and then return to 0, so reads of index 0 return 0.
REQ-030 When CONTROL_V3_IP_SELF_CLEAR_EN is undefined, register 0 is an ordinary RW register.

Verification
REQ-031 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read them back -> data matches, all RESP=OKAY, wr_pulse[0..3] each high one cycle.
REQ-032 W first (0xDEADBEEF), AW 3 cycles later to 0x4 -> BVALID 1 cycle after the AW handshake; ctrl_q reg1=0xDEADBEEF.
REQ-033 Reg2=0xFFFFFFFF, write 0x00000000 with WSTRB=4'b0101 -> readback 0xFF00FF00.
REQ-034 status_i reg4=0xA5A5A5A5: read 0x10 -> 0xA5A5A5A5 OKAY; write 0x10 -> SLVERR, value unchanged; read 0x3C -> 0, SLVERR.
REQ-035 BREADY held low 5 cycles -> BVALID/BRESP stable and AWREADY=0; ARESET pulse during W_RESP -> BVALID=0 next cycle, all regs 0.
REQ-036 With SELF_CLEAR_EN defined: write 0x1 to 0x0 -> ctrl_q[0] high one cycle, read 0x0 returns 0.
